// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU instruction path (issuer and scheduler).
package npu_pkg;

    // Scheduler non-IDLE state count; the issuer holds instr for exactly this many cycles after start.
    localparam int NPU_SCHED_HOLD = 3;
    localparam int NPU_W_IN       = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } issuer_state_e;

endpackage

// File: rtl/npu_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with an explicit level counter and synchronous flush.
module npu_sync_fifo
    import npu_pkg::*;
#(
    parameter int W     = NPU_W_IN,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [W-1:0]           head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;

    assign full      = (level_q == LEVEL_FULL);
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign head_data = mem_q[rd_ptr_q];

    // Flush overrides both ports so a same-cycle push or pop cannot leak past the clear.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that skips an assignment would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the level counter keeps stale words from being consumed.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/npu_instr_issuer.sv
// Queues host instruction bytes and issues them to npu_scheduler with a start pulse and a fixed hold window.
// Optional issue counter enabled by defining NPU_ISSUE_PERF_EN.
module npu_instr_issuer
    import npu_pkg::*;
#(
    parameter int W_IN        = NPU_W_IN,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = NPU_SCHED_HOLD,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   host_valid,
    input  logic [W_IN-1:0]        host_instr,
    output logic                   host_ready,
    input  logic                   flush,
    output logic [W_IN-1:0]        instr,
    output logic                   start,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level
`ifdef NPU_ISSUE_PERF_EN
    ,
    output logic [CNT_W-1:0]       issue_count
`endif
);

    localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HCNT_W-1:0] HCNT_LOAD = HCNT_W'(HOLD_CYCLES - 1);

    issuer_state_e     state_q, state_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [W_IN-1:0]   instr_q, instr_d;
    logic              start_q, start_d;

    logic              fifo_push, fifo_pop;
    logic              fifo_full, fifo_empty;
    logic [W_IN-1:0]   fifo_head;

    // A pop frees a slot only after the edge, so full alone gates the host.
    assign host_ready = !fifo_full && !flush;
    assign fifo_push  = host_valid && host_ready;

    npu_sync_fifo #(
        .W     (W_IN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (host_instr),
        .pop       (fifo_pop),
        .flush     (flush),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        instr_d  = instr_q;
        start_d  = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !flush) begin
                    instr_d  = fifo_head;
                    fifo_pop = 1'b1;
                    start_d  = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                hcnt_d  = HCNT_LOAD;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (hcnt_q != '0) begin
                    hcnt_d = hcnt_q - 1'b1;
                end else if (!fifo_empty && !flush) begin
                    // Back-to-back issue; a concurrent flush wins and drops us to idle instead.
                    instr_d  = fifo_head;
                    fifo_pop = 1'b1;
                    start_d  = 1'b1;
                    state_d  = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            instr_q <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            instr_q <= instr_d;
            start_q <= start_d;
        end
    end

    assign instr = instr_q;
    assign start = start_q;
    assign busy  = (state_q != S_IDLE);

`ifdef NPU_ISSUE_PERF_EN
    logic [CNT_W-1:0] issue_count_q, issue_count_d;

    // Saturating count of issues; flush leaves it alone, only rst_n clears it.
    always_comb begin
        issue_count_d = issue_count_q;
        if (start_d && (issue_count_q != '1)) issue_count_d = issue_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) issue_count_q <= '0;
        else        issue_count_q <= issue_count_d;
    end

    assign issue_count = issue_count_q;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule
